wide_add_stream: RTL

Streaming front/back end for the 512-bit ripple adder `adder512`. It deserialises two 512-bit operands from a narrow valid/ready word stream, least-significant word first, and presents them with a carry-in to one `adder512` instance. It registers the 512-bit sum and carry-out, then serialises the result back onto a narrow output stream. It sits between the system bus and the wide adder, so `adder512` needs no ports wider than the bus.

---
 rtl/wide_add_pkg.sv | 9 +
 rtl/wide_add_stream_if.sv | 20 ++
 rtl/adder512.sv | 12 +
 rtl/wide_add_stream.sv | 88 ++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared datapath width, FSM state type and beat-counter sizing
// for wide_add_stream and adder512.
package wide_add_pkg;
    localparam int WIDE_W = 512;
    typedef enum logic [1:0] {LOAD, ADD, DRAIN} wide_add_state_t;
    function automatic int beat_w(input int word_w);
        return $clog2(WIDE_W / word_w);
    endfunction
endpackage

// File: rtl/wide_add_stream_if.sv
// wide_add_stream_if: narrow operand and result word streams of wide_add_stream.
// out_ovf exists only when WIDE_ADD_OVF_EN is defined.
interface wide_add_stream_if #(parameter int WORD_W = 32);
    logic              in_valid, in_ready, in_cin;
    logic [WORD_W-1:0] in_a, in_b;
    logic              out_valid, out_ready, out_last, out_cout;
    logic [WORD_W-1:0] out_sum;
`ifdef WIDE_ADD_OVF_EN
    logic              out_ovf;
    modport slave (input in_valid, in_a, in_b, in_cin, out_ready,
                   output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf);
    modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                    input in_ready, out_valid, out_sum, out_last, out_cout, out_ovf);
`else
    modport slave (input in_valid, in_a, in_b, in_cin, out_ready,
                   output in_ready, out_valid, out_sum, out_last, out_cout);
    modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                    input in_ready, out_valid, out_sum, out_last, out_cout);
`endif
endinterface

// File: rtl/adder512.sv
// adder512: full-width ripple adder, {cout, sum} = a + b + cin modulo 2^513.
module adder512
    import wide_add_pkg::*;
(
    input  logic [WIDE_W-1:0] a,
    input  logic [WIDE_W-1:0] b,
    input  logic              cin,
    output logic [WIDE_W-1:0] sum,
    output logic              cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDE_W{1'b0}}, cin};
endmodule

// File: rtl/wide_add_stream.sv
// wide_add_stream: deserialises two 512-bit operands from a word stream, adds them in
// one cycle through adder512 and serialises the sum back out. WIDE_ADD_OVF_EN adds out_ovf.
module wide_add_stream
    import wide_add_pkg::*;
#(
    parameter int WORD_W = 32
)
(
    input  logic            clk,
    input  logic            rst,
    wide_add_stream_if.slave bus
);
    localparam int BEATS = WIDE_W / WORD_W;
    localparam int BW = beat_w(WORD_W);

    if ((WORD_W != 8 && WORD_W != 16 && WORD_W != 32 && WORD_W != 64) || (WIDE_W % WORD_W) != 0) begin : g_bad_word_w
        $error("wide_add_stream: illegal WORD_W %0d", WORD_W);
    end

    wide_add_state_t                 state;
    logic [BW-1:0]                   beat;
    logic [BEATS-1:0][WORD_W-1:0]    a, b, sum;
    logic [WIDE_W-1:0]               add_sum;
    logic                            cin, cout, add_cout;
    logic                            in_ready, out_valid, last_beat, in_hs, out_hs;

    assign last_beat = beat == BW'(BEATS - 1);
    // Ready/valid are state decodes, masked while reset is held.
    assign in_ready = state == LOAD && !rst;
    assign out_valid = state == DRAIN && !rst;
    assign in_hs = bus.in_valid && in_ready;
    assign out_hs = out_valid && bus.out_ready;

    assign bus.in_ready = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum = sum[beat];
    assign bus.out_last = out_valid && last_beat;
    assign bus.out_cout = out_valid && last_beat && cout;

    adder512 u_adder (
        .a(a),
        .b(b),
        .cin(cin),
        .sum(add_sum),
        .cout(add_cout)
    );

`ifdef WIDE_ADD_OVF_EN
    logic ovf;
    assign bus.out_ovf = out_valid && last_beat && ovf;
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (state == ADD)
            ovf <= (a[BEATS-1][WORD_W-1] == b[BEATS-1][WORD_W-1]) && (add_sum[WIDE_W-1] != a[BEATS-1][WORD_W-1]);
    end
`endif

    // BEATS is a power of two, so beat wraps to 0 on the final handshake by itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            beat <= '0;
            cin <= 1'b0;
            cout <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_hs) begin
                    a[beat] <= bus.in_a;
                    b[beat] <= bus.in_b;
                    cin <= beat == '0 ? bus.in_cin : cin;
                    beat <= beat + 1'b1;
                    state <= last_beat ? ADD : LOAD;
                end
                ADD: begin
                    sum <= add_sum;
                    cout <= add_cout;
                    state <= DRAIN;
                end
                DRAIN: if (out_hs) begin
                    beat <= beat + 1'b1;
                    state <= last_beat ? LOAD : DRAIN;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
